// File: rtl/dma_rd_channel.sv
// dma_rd_channel
//   Read half of the DMA engine. A single rd_go command (rd_addr, rd_size)
//   is turned into rd_size sequential cache-line read requests on an
//   in-order memory request/response bus. Responses land in a
//   first-word-fall-through FIFO that the AFU pops with rd_en.
//   A request is only issued while outstanding + fifo_count < FIFO_DEPTH,
//   so every response is guaranteed a FIFO slot.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   rd_go                 single-cycle transfer start
//   rd_addr, rd_size      start line address / line count, sampled on rd_go
//   rd_en                 pop FIFO head (ignored while empty)
//   rd_data, empty        FIFO head and its emptiness flag
//   rd_done               all rd_size lines have been popped
//   mem_req_valid/ready   request handshake, mem_req_addr = line address
//   mem_rsp_valid/data    in-order read responses
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no transfer since reset; waiting for rd_go
// ISSUE  | issuing requests (credit permitting) until issued == size
// DRAIN  | all requests issued; waiting for popped == size
// DONE   | transfer complete, rd_done high until next rd_go or reset

module dma_rd_channel #(
  parameter int ADDR_WIDTH = 42,
  parameter int DATA_WIDTH = 512,
  parameter int FIFO_DEPTH = 16,
  parameter int SIZE_WIDTH = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_go,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [SIZE_WIDTH-1:0] rd_size,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  rd_done,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SIZE_WIDTH-1:0] size_q, size_d;
  logic [SIZE_WIDTH-1:0] issued_q, issued_d;
  logic [SIZE_WIDTH-1:0] popped_q, popped_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [CW-1:0]         fifo_count_q, fifo_count_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];

  logic [CW:0] credits_used;
  logic        credit_ok;
  logic        req_valid;
  logic        req_fire;
  logic        rsp_wr;
  logic        pop;

  // Handshake qualifiers; all depend only on registered state, so
  // mem_req_valid has no combinational path from mem_req_ready.
  always_comb begin
    credits_used = {1'b0, outstanding_q} + {1'b0, fifo_count_q};
    credit_ok    = credits_used < DEPTH_W;
    req_valid    = (state_q == ST_ISSUE) && (issued_q != size_q) && credit_ok;
    req_fire     = req_valid && mem_req_ready;
    // A response with nothing outstanding is stale (e.g. issued before a
    // reset) and has no reserved slot, so it is dropped.
    rsp_wr       = mem_rsp_valid && (outstanding_q != '0);
    pop          = rd_en && (fifo_count_q != '0);
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    size_d        = size_q;
    issued_d      = issued_q;
    popped_d      = popped_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    // Request, response and pop each move their own counter; the sums net.
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_wr);
    fifo_count_d  = fifo_count_q + CW'(rsp_wr) - CW'(pop);

    if (rsp_wr) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      popped_d = popped_q + SIZE_WIDTH'(1);
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (rd_go) begin
          addr_d   = rd_addr;
          size_d   = rd_size;
          issued_d = '0;
          popped_d = '0;
          state_d  = (rd_size == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (req_fire) begin
          addr_d   = addr_q + ADDR_WIDTH'(1);
          issued_d = issued_q + SIZE_WIDTH'(1);
          if (issued_d == size_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (popped_d == size_q) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      size_q        <= '0;
      issued_q      <= '0;
      popped_q      <= '0;
      outstanding_q <= '0;
      fifo_count_q  <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      size_q        <= size_d;
      issued_q      <= issued_d;
      popped_q      <= popped_d;
      outstanding_q <= outstanding_d;
      fifo_count_q  <= fifo_count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Storage is not reset; the head is masked while empty instead.
  always_ff @(posedge clk) begin
    if (rsp_wr) fifo_mem_q[wr_ptr_q] <= mem_rsp_data;
  end

  assign empty         = (fifo_count_q == '0);
  assign rd_data       = empty ? '0 : fifo_mem_q[rd_ptr_q];
  assign rd_done       = (state_q == ST_DONE);
  assign mem_req_valid = req_valid;
  assign mem_req_addr  = addr_q;

endmodule

// File: tb/tb_dma_rd_channel.sv
module tb_dma_rd_channel;

  localparam int AW    = 16;
  localparam int DW    = 64;
  localparam int DEPTH = 16;
  localparam int SW    = AW + 1;
  localparam int LAT   = 3;

  logic          clk;
  logic          rst_n;
  logic          rd_go;
  logic [AW-1:0] rd_addr;
  logic [SW-1:0] rd_size;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          rd_done;
  logic          mem_req_valid;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_ready;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;

  dma_rd_channel #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .SIZE_WIDTH(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rd_go(rd_go), .rd_addr(rd_addr),
    .rd_size(rd_size), .rd_en(rd_en), .rd_data(rd_data), .empty(empty),
    .rd_done(rd_done), .mem_req_valid(mem_req_valid),
    .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } pend_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [SW-1:0] size;
    bit            rand_ready;
    logic [AW-1:0] exp_last;
    int            exp_reqs;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  pend_t         pend_q[$];
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] exp_req_addr;
  logic [AW-1:0] last_req_addr;
  logic [AW-1:0] prev_addr;
  bit            prev_stall;
  bit            go_req;
  bit            inject_stale;
  bit            ready_rand;
  logic          ready_val;
  logic          rden_val;
  int            req_count;
  int            pop_count;
  int            last_pop_cyc;
  int            go_cyc;
  int            done_cyc;

  function automatic logic [DW-1:0] line_data(input logic [AW-1:0] a);
    return {~a, a, a ^ 16'h5A5A, a + 16'h1111};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs at the falling edge, then observe what the
  // next rising edge will do with them.
  task automatic step();
    logic [AW-1:0] a;
    @(negedge clk);
    cyc++;
    rd_go = go_req;
    go_req = 1'b0;
    mem_req_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
    rd_en = rden_val;
    if (inject_stale) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 64'hDEAD_BEEF_0BAD_F00D;
      inject_stale  = 1'b0;
    end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      a = pend_q[0].addr;
      pend_q.pop_front();
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = line_data(a);
      exp_q.push_back(a);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end
    #1;
    if (prev_stall) begin
      chk("stall_valid", 64'(mem_req_valid), 64'd1);
      chk("stall_addr", 64'(mem_req_addr), 64'(prev_addr));
    end
    if (mem_req_valid && mem_req_ready) begin
      chk("req_addr", 64'(mem_req_addr), 64'(exp_req_addr));
      last_req_addr = mem_req_addr;
      exp_req_addr  = exp_req_addr + 16'd1;
      req_count++;
      pend_q.push_back('{mem_req_addr, cyc + LAT});
    end
    if (rd_en && !empty) begin
      if (exp_q.size() == 0) chk("pop_unexpected", 64'd0, 64'd1);
      else chk("pop_data", rd_data, line_data(exp_q.pop_front()));
      pop_count++;
      last_pop_cyc = cyc;
    end
    prev_stall = mem_req_valid && !mem_req_ready;
    prev_addr  = mem_req_addr;
  endtask

  task automatic start(input logic [AW-1:0] a, input logic [SW-1:0] s);
    rd_addr      = a;
    rd_size      = s;
    exp_req_addr = a;
    req_count    = 0;
    pop_count    = 0;
    go_req       = 1'b1;
    step();
    go_cyc = cyc;
  endtask

  task automatic wait_done(input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (rd_done) begin
        found = 1'b1;
        done_cyc = cyc;
        break;
      end
    end
    if (!found) chk("done_timeout", 64'd0, 64'd1);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{16'h0100, 17'd4,  1'b0, 16'h0103, 4};
    vecs[1] = '{16'h2000, 17'd1,  1'b1, 16'h2000, 1};
    vecs[2] = '{16'hFFFF, 17'd2,  1'b0, 16'h0000, 2};
    vecs[3] = '{16'h0040, 17'd20, 1'b1, 16'h0053, 20};
    vecs[4] = '{16'h1234, 17'd0,  1'b0, 16'h0000, 0};
    vecs[5] = '{16'hFFF0, 17'd33, 1'b1, 16'h0010, 33};

    rst_n = 1'b0;
    rd_go = 1'b0; rd_addr = '0; rd_size = '0; rd_en = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    go_req = 0; inject_stale = 0; ready_rand = 0; ready_val = 1'b1;
    rden_val = 1'b0; prev_stall = 0; req_count = 0; pop_count = 0;
    last_pop_cyc = 0; exp_req_addr = '0; last_req_addr = '0; prev_addr = '0;

    step();
    step();
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_req_addr", 64'(mem_req_addr), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_rd_done", 64'(rd_done), 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    rst_n = 1'b1;
    step();

    // Table of complete transfers, rd_en tied high.
    for (int v = 0; v < 6; v++) begin
      ready_rand = vecs[v].rand_ready;
      ready_val  = 1'b1;
      rden_val   = 1'b1;
      start(vecs[v].addr, vecs[v].size);
      wait_done(2000);
      chk($sformatf("v%0d_req_count", v), 64'(req_count), 64'(vecs[v].exp_reqs));
      chk($sformatf("v%0d_pop_count", v), 64'(pop_count), 64'(vecs[v].exp_reqs));
      if (vecs[v].exp_reqs == 0)
        chk($sformatf("v%0d_done_lat", v), 64'(done_cyc - go_cyc), 64'd1);
      else begin
        chk($sformatf("v%0d_done_lat", v), 64'(done_cyc - last_pop_cyc), 64'd1);
        chk($sformatf("v%0d_last_addr", v), 64'(last_req_addr), 64'(vecs[v].exp_last));
      end
      for (int i = 0; i < 3; i++) step();
      chk($sformatf("v%0d_no_extra_req", v), 64'(req_count), 64'(vecs[v].exp_reqs));
      chk($sformatf("v%0d_done_held", v), 64'(rd_done), 64'd1);
      chk($sformatf("v%0d_empty", v), 64'(empty), 64'd1);
      chk($sformatf("v%0d_valid_low", v), 64'(mem_req_valid), 64'd0);
    end

    // FIFO backpressure: credit caps requests at DEPTH.
    ready_rand = 0; ready_val = 1'b1; rden_val = 1'b0;
    start(16'h0500, 17'd40);
    for (int i = 0; i < 60; i++) step();
    chk("bp_req_cap", 64'(req_count), 64'd16);
    chk("bp_valid_low", 64'(mem_req_valid), 64'd0);
    chk("bp_not_empty", 64'(empty), 64'd0);
    rden_val = 1'b1;
    step();
    rden_val = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("bp_one_more_req", 64'(req_count), 64'd17);
    chk("bp_one_pop", 64'(pop_count), 64'd1);
    rden_val = 1'b1;
    wait_done(1000);
    chk("bp_total_reqs", 64'(req_count), 64'd40);
    chk("bp_total_pops", 64'(pop_count), 64'd40);
    chk("bp_last_addr", 64'(last_req_addr), 64'h0527);
    chk("bp_exp_q_drained", 64'(exp_q.size()), 64'd0);

    // rd_go during ISSUE is ignored; rd_en while empty pops nothing.
    ready_val = 1'b0; rden_val = 1'b1;
    start(16'h0800, 17'd6);
    for (int i = 0; i < 3; i++) step();
    chk("empty_pop_count", 64'(pop_count), 64'd0);
    chk("empty_still", 64'(empty), 64'd1);
    rd_addr = 16'h0ABC;
    rd_size = 17'd2;
    go_req  = 1'b1;
    step();
    ready_val = 1'b1;
    wait_done(500);
    chk("go_ign_reqs", 64'(req_count), 64'd6);
    chk("go_ign_pops", 64'(pop_count), 64'd6);
    chk("go_ign_last", 64'(last_req_addr), 64'h0805);

    // Asynchronous reset mid-DRAIN, stale response, then a clean transfer.
    ready_val = 1'b1; rden_val = 1'b0;
    start(16'h0700, 17'd8);
    for (int i = 0; i < 20; i++) step();
    chk("drain_reqs", 64'(req_count), 64'd8);
    chk("drain_not_empty", 64'(empty), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_empty", 64'(empty), 64'd1);
    chk("arst_rd_done", 64'(rd_done), 64'd0);
    chk("arst_valid", 64'(mem_req_valid), 64'd0);
    pend_q.delete();
    exp_q.delete();
    prev_stall = 0;
    step();
    rst_n = 1'b1;
    inject_stale = 1'b1;
    step();
    rden_val = 1'b1;
    start(16'h0900, 17'd3);
    wait_done(500);
    chk("post_rst_reqs", 64'(req_count), 64'd3);
    chk("post_rst_pops", 64'(pop_count), 64'd3);
    chk("post_rst_last", 64'(last_req_addr), 64'h0902);
    chk("post_rst_done_lat", 64'(done_cyc - last_pop_cyc), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
